// File: rtl/if_id_imm_stage.sv
// IF/ID stage: 2-entry skid buffer with per-entry immediate/extend-mode decode for sign_ext; HALT_DETECT_EN adds halt stall.
// Latency: instr accepted at edge N is on the outputs after edge N when the buffer was empty.
// Backpressure: registered in_ready drops when the buffer will hold two entries (or a HALT was accepted).
module if_id_imm_stage #(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [15:0]        imm_field,
    output logic [1:0]         ext_mode,
    output logic               halt_seen
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [15:0]        imm;
        logic [1:0]         mode;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    function automatic entry_t make_entry(input logic [INSTR_W-1:0] instr,
                                          input logic [PC_W-1:0]    pc);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.imm   = 16'd0;
        e.mode  = 2'd0;
        case (instr[15:11])
            5'b01010, 5'b01011: begin
                e.imm  = {11'd0, instr[4:0]};
                e.mode = 2'd0;
            end
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
                e.imm  = {11'd0, instr[4:0]};
                e.mode = 2'd1;
            end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                e.imm  = {11'd0, instr[4:0]};
                e.mode = 2'd0;
            end
            5'b10010: begin
                e.imm  = {8'd0, instr[7:0]};
                e.mode = 2'd0;
            end
            5'b01100, 5'b01101, 5'b01110, 5'b01111,
            5'b11000, 5'b00101, 5'b00111: begin
                e.imm  = {8'd0, instr[7:0]};
                e.mode = 2'd2;
            end
            5'b00100, 5'b00110: begin
                e.imm  = {5'd0, instr[10:0]};
                e.mode = 2'd3;
            end
            default: begin
                e.imm  = 16'd0;
                e.mode = 2'd0;
            end
        endcase
        return e;
    endfunction

    state_t state_q, state_d;
    entry_t head_q, skid_q, new_entry, nop_entry;
    logic   in_ready_q;
    logic   in_xfer, out_xfer;
    logic   halt_d;

    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;
    assign new_entry = make_entry(instr_in, pc_in);

    always_comb begin
        nop_entry       = '0;
        nop_entry.instr = NOP_INSTR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_xfer) state_d = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state_d = TWO;
                    else if (!in_xfer && out_xfer) state_d = EMPTY;
                end
                TWO:     if (out_xfer) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
    end

`ifdef HALT_DETECT_EN
    logic halt_q;

    // Once a HALT is taken nothing more enters until a redirect or reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            halt_q <= 1'b0;
        end else if (in_xfer && (instr_in[15:11] == 5'b00000)) begin
            halt_q <= 1'b1;
        end
    end

    assign halt_d    = halt_q | (in_xfer & (instr_in[15:11] == 5'b00000));
    assign halt_seen = halt_q;
`else
    assign halt_d    = 1'b0;
    assign halt_seen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= nop_entry;
            skid_q     <= nop_entry;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            head_q     <= nop_entry;
            skid_q     <= nop_entry;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) head_q <= new_entry;
                ONE: begin
                    if (in_xfer && out_xfer) head_q <= new_entry;
                    else if (in_xfer)        skid_q <= new_entry;
                    else if (out_xfer)       head_q <= nop_entry;
                end
                TWO:     if (out_xfer) head_q <= skid_q;
                default: head_q <= nop_entry;
            endcase
            in_ready_q <= (state_d != TWO) && !halt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign instr_out = head_q.instr;
    assign pc_out    = head_q.pc;
    assign imm_field = head_q.imm;
    assign ext_mode  = head_q.mode;

endmodule

// File: tb/tb_if_id_imm_stage.sv
// Bench for if_id_imm_stage: directed cases then randomized traffic against a queue-based reference.
module tb_if_id_imm_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, halt_seen;
    logic [15:0] instr_in, pc_in, instr_out, pc_out, imm_field;
    logic [1:0]  ext_mode;

    always #5 clk = ~clk;

    if_id_imm_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
        .pc_out(pc_out), .imm_field(imm_field), .ext_mode(ext_mode),
        .halt_seen(halt_seen)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] imm;
        logic [1:0]  mode;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pops = 0;
    bit   started = 1'b0;
    bit   halt_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode: field width and extension kind chosen from the opcode value.
    function automatic exp_t ref_entry(input logic [15:0] instr, input logic [15:0] pc);
        exp_t e;
        int   op = int'(instr[15:11]);
        int   w;
        int   m;
        if (op inside {10, 11})                      begin w = 5;  m = 0; end
        else if (op inside {8, 9, 16, 17, 19})       begin w = 5;  m = 1; end
        else if (op inside {[20:23]})                begin w = 5;  m = 0; end
        else if (op == 18)                           begin w = 8;  m = 0; end
        else if (op inside {[12:15], 24, 5, 7})      begin w = 8;  m = 2; end
        else if (op inside {4, 6})                   begin w = 11; m = 3; end
        else                                         begin w = 0;  m = 0; end
        e.instr = instr;
        e.pc    = pc;
        e.imm   = instr & 16'((32'd1 << w) - 1);
        e.mode  = 2'(m);
        return e;
    endfunction

    // Expected-response producer: records every accepted fetch.
    always @(negedge clk) begin
        #1;
        if (rst || flush) begin
            q.delete();
            halt_m = 1'b0;
        end else if (started && in_valid && in_ready) begin
            q.push_back(ref_entry(instr_in, pc_in));
`ifdef HALT_DETECT_EN
            if (instr_in[15:11] == 5'd0) halt_m = 1'b1;
`endif
        end
    end

    // Monitor: compares the presented head and handshake signals with the reference.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("in_ready", 32'(in_ready), 32'((q.size() < 2) && !halt_m));
            check("halt_seen", 32'(halt_seen), 32'(halt_m));
            if (out_valid && q.size() > 0) begin
                check("head_instr", 32'(instr_out), 32'(q[0].instr));
                check("head_pc", 32'(pc_out), 32'(q[0].pc));
                check("head_imm", 32'(imm_field), 32'(q[0].imm));
                check("head_mode", 32'(ext_mode), 32'(q[0].mode));
                if (out_ready && !flush && !rst) begin
                    q.delete(0);
                    pops++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] s_instr [3] = '{16'h2405, 16'h6180, 16'h5105};
    logic [15:0] s_imm   [3] = '{16'h0405, 16'h0080, 16'h0005};
    logic [1:0]  s_mode  [3] = '{2'd3, 2'd2, 2'd0};

    initial begin
        int p0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr_in = 16'h0; pc_in = 16'h0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_in_ready", 32'(in_ready), 32'(1'b1));
        check("rst_instr_out", 32'(instr_out), 32'(16'h0800));
        check("rst_pc_out", 32'(pc_out), 32'(16'h0));
        check("rst_imm", 32'(imm_field), 32'(16'h0));
        check("rst_ext_mode", 32'(ext_mode), 32'(2'd0));
        check("rst_halt", 32'(halt_seen), 32'(1'b0));
        tick();
        rst = 1'b0;
        started = 1'b1;

        // Single ADDI straight through
        in_valid = 1'b1; instr_in = 16'h4130; pc_in = 16'h0002; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("addi_imm", 32'(imm_field), 32'(16'h0010));
        check("addi_mode", 32'(ext_mode), 32'(2'd1));
        tick();

        // Back-to-back stream, one per cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; instr_in = s_instr[i]; pc_in = 16'(16'h0010 + 2 * i);
            @(negedge clk);
            if (i > 0) begin
                check("stream_mode", 32'(ext_mode), 32'(s_mode[i-1]));
                check("stream_imm", 32'(imm_field), 32'(s_imm[i-1]));
                check("stream_in_ready", 32'(in_ready), 32'(1'b1));
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_mode", 32'(ext_mode), 32'(s_mode[2]));
        check("stream_imm", 32'(imm_field), 32'(s_imm[2]));
        tick();

        // Backpressure: fill both entries, hold a third, then release
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h4001; pc_in = 16'h0100;
        tick();
        instr_in = 16'h9234; pc_in = 16'h0102;
        tick();
        instr_in = 16'h2FFF; pc_in = 16'h0104;
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'(1'b0));
        repeat (2) tick();
        @(negedge clk);
        check("bp_held_in_ready", 32'(in_ready), 32'(1'b0));
        check("bp_head_first", 32'(instr_out), 32'(16'h4001));
        tick();
        p0 = pops;
        out_ready = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        tick();
        check("bp_drained_three", 32'(pops - p0), 32'd3);

        // Flush while holding two entries, with a fetch offered
        out_ready = 1'b0;
        in_valid = 1'b1; instr_in = 16'h7AAA; pc_in = 16'h0200;
        tick();
        instr_in = 16'hC0FE; pc_in = 16'h0202;
        tick();
        instr_in = 16'hA123; pc_in = 16'h0204; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'(1'b0));
        check("flush_in_ready", 32'(in_ready), 32'(1'b1));
        check("flush_instr_nop", 32'(instr_out), 32'(16'h0800));
        tick();

`ifdef HALT_DETECT_EN
        out_ready = 1'b1;
        in_valid = 1'b1; instr_in = 16'h0000; pc_in = 16'h0300;
        tick();
        instr_in = 16'h4130; pc_in = 16'h0302;
        repeat (3) tick();
        @(negedge clk);
        check("halt_seen_set", 32'(halt_seen), 32'(1'b1));
        check("halt_in_ready", 32'(in_ready), 32'(1'b0));
        check("halt_drained", 32'(out_valid), 32'(1'b0));
        tick();
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("halt_cleared", 32'(halt_seen), 32'(1'b0));
        tick();
`endif

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            instr_in  = 16'($urandom);
            pc_in     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("final_empty_model", 32'(q.size()), 32'd0);
        check("final_out_valid", 32'(out_valid), 32'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
